// File: rtl/stage_5_message_dispatch_module.sv
// Stage-5 message dispatch: drops default-mux slots, compacts up to three
// kept messages per cycle into a small FIFO and drains one per cycle to
// the stage-6 field extractor over a valid/ready handshake.
module stage_5_message_dispatch_module #(
   parameter int unsigned         MSG_W       = 336,
   parameter int unsigned         MUX_W       = 3,
   parameter int unsigned         NT_W        = 3,
   parameter logic [MUX_W-1:0]    MUX_DEFAULT = {MUX_W{1'b1}},
   parameter int unsigned         DEPTH       = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid_m1,
   input  logic                   in_valid_m2,
   input  logic                   in_valid_m3,
   input  logic [MSG_W-1:0]       message_fast_1,
   input  logic [MSG_W-1:0]       message_fast_2,
   input  logic [MSG_W-1:0]       message_fast_3,
   input  logic [MUX_W-1:0]       message_mux_control_m1,
   input  logic [MUX_W-1:0]       message_mux_control_m2,
   input  logic [MUX_W-1:0]       message_mux_control_m3,
   input  logic [NT_W-1:0]        N_type_control_m1,
   input  logic [NT_W-1:0]        N_type_control_m2,
   input  logic [NT_W-1:0]        N_type_control_m3,
   output logic                   in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [MSG_W-1:0]       out_message,
   output logic [MUX_W-1:0]       out_mux_control,
   output logic [NT_W-1:0]        out_N_type,
   output logic [15:0]            drop_count,
   output logic                   overflow_err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] IN_RDY_MAX = CW'(DEPTH - 3);

   logic [MSG_W-1:0] msg_mem [DEPTH];
   logic [MUX_W-1:0] mux_mem [DEPTH];
   logic [NT_W-1:0]  nt_mem  [DEPTH];

   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   drop_q, drop_d;
   logic          ovf_q, ovf_d;

   logic [MSG_W-1:0] msg_s  [3];
   logic [MUX_W-1:0] mux_s  [3];
   logic [NT_W-1:0]  nt_s   [3];
   logic [PW-1:0]    addr_s [3];
   logic [2:0]       vld, keep, drp, we;
   logic [1:0]       n_push, n_drop;
   logic [16:0]      drop_sum;
   logic             pop;

   assign vld = {in_valid_m3, in_valid_m2, in_valid_m1};

   // gather the three input slots into indexable form
   always_comb begin
      msg_s[0] = message_fast_1;
      msg_s[1] = message_fast_2;
      msg_s[2] = message_fast_3;
      mux_s[0] = message_mux_control_m1;
      mux_s[1] = message_mux_control_m2;
      mux_s[2] = message_mux_control_m3;
      nt_s[0]  = N_type_control_m1;
      nt_s[1]  = N_type_control_m2;
      nt_s[2]  = N_type_control_m3;
   end

   assign in_ready  = (cnt_q <= IN_RDY_MAX);
   assign out_valid = (cnt_q != '0);
   assign pop       = out_valid & out_ready;

   // classify slots, compute compacted write addresses and next state
   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         keep[i] = vld[i] && (mux_s[i] != MUX_DEFAULT);
         drp[i]  = vld[i] && (mux_s[i] == MUX_DEFAULT);
         we[i]   = in_ready && keep[i];
      end
      // each kept slot lands after the kept slots before it
      addr_s[0] = wp_q;
      addr_s[1] = wp_q + PW'(keep[0]);
      addr_s[2] = wp_q + PW'({1'b0, keep[0]} + {1'b0, keep[1]});
      n_push    = in_ready ? ({1'b0, keep[0]} + {1'b0, keep[1]} + {1'b0, keep[2]}) : 2'd0;
      n_drop    = in_ready ? ({1'b0, drp[0]} + {1'b0, drp[1]} + {1'b0, drp[2]}) : 2'd0;
      drop_sum  = {1'b0, drop_q} + 17'(n_drop);
      drop_d    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      wp_d      = wp_q + PW'(n_push);
      rp_d      = rp_q + PW'(pop);
      cnt_d     = cnt_q + CW'(n_push) - CW'(pop);
      ovf_d     = ovf_q | ((|vld) & ~in_ready);
   end

   // pointer, occupancy and status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q   <= '0;
         rp_q   <= '0;
         cnt_q  <= '0;
         drop_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         cnt_q  <= cnt_d;
         drop_q <= drop_d;
         ovf_q  <= ovf_d;
      end
   end

   // storage array; contents deliberately not reset
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 3; i++) begin
         if (we[i]) begin
            msg_mem[addr_s[i]] <= msg_s[i];
            mux_mem[addr_s[i]] <= mux_s[i];
            nt_mem[addr_s[i]]  <= nt_s[i];
         end
      end
   end

   assign out_message     = msg_mem[rp_q];
   assign out_mux_control = mux_mem[rp_q];
   assign out_N_type      = nt_mem[rp_q];
   assign drop_count      = drop_q;
   assign overflow_err    = ovf_q;

endmodule

// File: tb/tb_stage_5_message_dispatch_module.sv
// Bench for stage_5_message_dispatch_module: driver keeps a queue-based
// reference of the FIFO, monitor checks every popped head entry.
module tb_stage_5_message_dispatch_module;

   localparam int unsigned MSG_W = 336;
   localparam int unsigned DEPTH = 8;
   localparam logic [2:0]  DEF   = 3'b111;

   typedef struct {
      logic [MSG_W-1:0] msg;
      logic [2:0]       mux;
      logic [2:0]       nt;
   } ent_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid_m1 = 1'b0, in_valid_m2 = 1'b0, in_valid_m3 = 1'b0;
   logic [MSG_W-1:0] message_fast_1 = '0, message_fast_2 = '0, message_fast_3 = '0;
   logic [2:0]       message_mux_control_m1 = '0, message_mux_control_m2 = '0, message_mux_control_m3 = '0;
   logic [2:0]       N_type_control_m1 = '0, N_type_control_m2 = '0, N_type_control_m3 = '0;
   logic             in_ready, out_valid;
   logic             out_ready = 1'b0;
   logic [MSG_W-1:0] out_message;
   logic [2:0]       out_mux_control, out_N_type;
   logic [15:0]      drop_count;
   logic             overflow_err;

   stage_5_message_dispatch_module #(
      .MSG_W(MSG_W), .MUX_W(3), .NT_W(3), .MUX_DEFAULT(DEF), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid_m1(in_valid_m1), .in_valid_m2(in_valid_m2), .in_valid_m3(in_valid_m3),
      .message_fast_1(message_fast_1), .message_fast_2(message_fast_2), .message_fast_3(message_fast_3),
      .message_mux_control_m1(message_mux_control_m1),
      .message_mux_control_m2(message_mux_control_m2),
      .message_mux_control_m3(message_mux_control_m3),
      .N_type_control_m1(N_type_control_m1), .N_type_control_m2(N_type_control_m2),
      .N_type_control_m3(N_type_control_m3),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_message(out_message), .out_mux_control(out_mux_control), .out_N_type(out_N_type),
      .drop_count(drop_count), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // reference model: FIFO contents, occupancy, drop total, sticky flag
   ent_t        exp_q[$];
   int          mcnt = 0;
   int unsigned mdrop = 0;
   bit          movf = 1'b0;

   // stimulus slots
   logic             s_v   [3];
   logic [MSG_W-1:0] s_msg [3];
   logic [2:0]       s_mux [3];
   logic [2:0]       s_nt  [3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [MSG_W-1:0] rmsg();
      logic [MSG_W-1:0] r;
      r = '0;
      for (int i = 0; i < 11; i++) r = {r[MSG_W-33:0], 32'($urandom)};
      return r;
   endfunction

   function automatic logic [2:0] rmux();
      if ($urandom_range(3) == 0) return DEF;
      return 3'($urandom_range(6));
   endfunction

   task automatic clear_slots();
      for (int i = 0; i < 3; i++) begin
         s_v[i] = 1'b0; s_msg[i] = '0; s_mux[i] = '0; s_nt[i] = '0;
      end
   endtask

   task automatic rand_slots(input int unsigned pv);
      for (int i = 0; i < 3; i++) begin
         s_v[i]   = ($urandom_range(99) < pv);
         s_msg[i] = rmsg();
         s_mux[i] = rmux();
         s_nt[i]  = 3'($urandom);
      end
   endtask

   // one clock cycle, entered and left at posedge+1
   task automatic step(input bit ordy);
      int k;
      bit anyv, accept;
      ent_t e;
      chk("out_valid", 32'(out_valid), 32'(mcnt != 0));
      chk("in_ready", 32'(in_ready), 32'((DEPTH - mcnt) >= 3));
      chk("drop_count", 32'(drop_count), mdrop);
      chk("overflow_err", 32'(overflow_err), 32'(movf));
      in_valid_m1 = s_v[0]; in_valid_m2 = s_v[1]; in_valid_m3 = s_v[2];
      message_fast_1 = s_msg[0]; message_fast_2 = s_msg[1]; message_fast_3 = s_msg[2];
      message_mux_control_m1 = s_mux[0]; message_mux_control_m2 = s_mux[1];
      message_mux_control_m3 = s_mux[2];
      N_type_control_m1 = s_nt[0]; N_type_control_m2 = s_nt[1]; N_type_control_m3 = s_nt[2];
      out_ready = ordy;
      k = 0;
      anyv = s_v[0] | s_v[1] | s_v[2];
      accept = (DEPTH - mcnt) >= 3;
      if (accept) begin
         for (int i = 0; i < 3; i++) begin
            if (s_v[i]) begin
               if (s_mux[i] == DEF) begin
                  if (mdrop < 65535) mdrop++;
               end else begin
                  e.msg = s_msg[i]; e.mux = s_mux[i]; e.nt = s_nt[i];
                  exp_q.push_back(e);
                  k++;
               end
            end
         end
      end else if (anyv) begin
         movf = 1'b1;
      end
      mcnt = mcnt + k - ((mcnt != 0 && ordy) ? 1 : 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_drop_count", 32'(drop_count), 32'd0);
      chk("rst_overflow", 32'(overflow_err), 32'd0);
      exp_q.delete();
      mcnt = 0; mdrop = 0; movf = 1'b0;
      clear_slots();
      in_valid_m1 = 1'b0; in_valid_m2 = 1'b0; in_valid_m3 = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // monitor: every handshake pops the oldest expected entry
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL pop_empty: DUT presented %0h but none expected", out_message);
            end else begin
               e = exp_q.pop_front();
               n_cmp++;
               if (out_message !== e.msg || out_mux_control !== e.mux || out_N_type !== e.nt) begin
                  n_err++;
                  $display("FAIL head: got msg %0h mux %0h nt %0h expected msg %0h mux %0h nt %0h",
                           out_message, out_mux_control, out_N_type, e.msg, e.mux, e.nt);
               end
            end
         end
      end
   end

   initial begin
      clear_slots();
      @(posedge clk);
      #1;
      do_reset();

      // single slot on m2
      clear_slots();
      s_v[1] = 1'b1; s_mux[1] = 3'b001; s_nt[1] = 3'b010; s_msg[1] = {42{8'hA5}};
      step(1'b0);
      clear_slots();
      step(1'b0);
      step(1'b1);
      step(1'b0);

      // compaction and drop: m1 dropped, m2 then m3 kept
      for (int i = 0; i < 3; i++) begin
         s_v[i] = 1'b1; s_msg[i] = rmsg(); s_nt[i] = 3'($urandom);
      end
      s_mux[0] = 3'b111; s_mux[1] = 3'b000; s_mux[2] = 3'b100;
      step(1'b0);
      clear_slots();
      for (int i = 0; i < 3; i++) step(1'b1);

      // fill until refused, then drain
      for (int g = 0; g < 3; g++) begin
         for (int i = 0; i < 3; i++) begin
            s_v[i] = 1'b1; s_msg[i] = rmsg(); s_mux[i] = 3'($urandom_range(6)); s_nt[i] = 3'($urandom);
         end
         step(1'b0);
      end
      clear_slots();
      for (int i = 0; i < 8; i++) step(1'b1);
      do_reset();

      // wrap: move pointers to 3, then 6, then write across the end
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 3; i++) begin
            s_v[i] = 1'b1; s_msg[i] = rmsg(); s_mux[i] = 3'($urandom_range(6)); s_nt[i] = 3'($urandom);
         end
         step(1'b0);
         clear_slots();
         for (int i = 0; i < 4; i++) step(1'b1);
      end

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rand_slots(60);
         step($urandom_range(1) == 1);
      end
      for (int i = 0; i < 10; i++) begin
         clear_slots();
         step(1'b1);
      end

      // saturation of drop_count
      for (int c = 0; c < 22000; c++) begin
         for (int i = 0; i < 3; i++) begin
            s_v[i] = 1'b1; s_mux[i] = DEF; s_msg[i] = '0; s_nt[i] = 3'($urandom);
         end
         step($urandom_range(1) == 1);
      end
      clear_slots();
      step(1'b0);
      chk("drop_saturated", 32'(drop_count), 32'h0000FFFF);

      // reset mid-stream with entries in flight
      rand_slots(100);
      for (int i = 0; i < 3; i++) s_mux[i] = 3'($urandom_range(6));
      step(1'b0);
      clear_slots();
      step(1'b0);
      do_reset();
      step(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/stage_5_message_dispatch_module.md
# stage_5_message_dispatch_module

Downstream neighbour of the stage-4 de-FAST control stage. Accepts up to three decoded FAST messages per cycle, each with its message-mux control and N-type control. Discards slots whose mux control is the default (unrecognised template) value, and compacts the rest in slot order into a small FIFO. Drains one message per cycle to the stage-6 field extractor over a valid/ready handshake.

## Interface
Parameters:
- `MSG_W`, 336, width of one FAST message (`fast_message_bits`).
- `MUX_W`, 3, message-mux control width (`message_mux_control_width`).
- `NT_W`, 3, N-type control width (`N_type_control_width`).
- `MUX_DEFAULT`, 3'b111, value of `message_mux_defaut`; a slot carrying it is dropped.
- `DEPTH`, 8, FIFO entries; power of two, at least 4.

Ports:
- `clk`  in  1  single clock, all logic rising-edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `in_valid_m1`, `in_valid_m2`, `in_valid_m3`  in  1 each  per-slot valid.
- `message_fast_1`, `message_fast_2`, `message_fast_3`  in  MSG_W each  messages.
- `message_mux_control_m1`, `message_mux_control_m2`, `message_mux_control_m3`  in  MUX_W each  per-slot mux control.
- `N_type_control_m1`, `N_type_control_m2`, `N_type_control_m3`  in  NT_W each  per-slot N-type.
- `in_ready`  out  1  group accepted this cycle if any `in_valid_mX` is high.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  consumer takes head.
- `out_message`  out  MSG_W  head message.
- `out_mux_control`  out  MUX_W  head mux control.
- `out_N_type`  out  NT_W  head N-type.
- `drop_count`  out  16  saturating count of dropped default-mux slots.
- `overflow_err`  out  1  sticky; set if any valid slot is presented while `in_ready` is 0.

## Operation
- Storage: DEPTH-entry array of {message, mux, N-type}. Write pointer `wp` and read pointer `rp`, each log2(DEPTH) bits, wrapping modulo DEPTH. Occupancy `cnt` is log2(DEPTH)+1 bits.
- `in_ready` = (DEPTH − `cnt`) ≥ 3, computed from registered `cnt` only. It is independent of `out_ready` and of the current input.
- Accept: when `in_ready` is 1, the kept slots are written this cycle. A slot is kept when its valid is high and its mux control ≠ MUX_DEFAULT.
  - Kept slots go to `wp`, `wp+1`, `wp+2` in order m1, m2, m3, with invalid or dropped slots skipped (compaction).
  - `wp` advances by the number of kept slots, k ∈ 0..3.
- Drop: a slot with valid=1 and mux = MUX_DEFAULT increments `drop_count`, but only if the group is accepted. Up to +3 per cycle; saturates at 16'hFFFF.
- Refused group: if any valid is high while `in_ready` is 0:
  - nothing is written and nothing is dropped;
  - `overflow_err` is set and held until reset.
  - Upstream is required to hold the group; the flag marks a protocol violation.
- Pop: when `out_valid` and `out_ready` are both 1, `rp` increments.
- Count update: `cnt` ← `cnt` + k − pop. Simultaneous push and pop in the same cycle is legal at any occupancy.
- Output: `out_valid` = (`cnt` ≠ 0). The `out_*` data ports are read combinationally from entry `rp`.
  - When `out_valid` is 0, `out_message`, `out_mux_control` and `out_N_type` are don't-care; the bench must not check them.
- N-type is carried unchanged for every kept slot, including non-N mux types.

## Timing
- Reset (async assert, sync release):
  - `wp`, `rp`, `cnt` = 0; `out_valid` = 0; `in_ready` = 1; `drop_count` = 0; `overflow_err` = 0.
  - Array contents are not reset.
- Latency: a slot accepted in cycle t appears at the head in cycle t+1 at the earliest. It reaches the head in t+1 only if the FIFO was empty or drained to it.
- Throughput: input up to 3 per cycle; output 1 per cycle. Sustained 3-wide input therefore throttles `in_ready`.
- Full boundary: `in_ready` falls when `cnt` ≥ DEPTH−2 (cnt ≥ 6 at DEPTH 8). A pop in the same cycle does not raise `in_ready` until the next cycle.
- Empty boundary: with `cnt` = 0, a same-cycle push is not visible at the output until the next cycle (no bypass).
- Wrap: pointer wrap from DEPTH−1 to 0 within a single 3-slot write must place entries contiguously modulo DEPTH.
- Reset asserted mid-burst: FIFO empties immediately and `out_valid` drops asynchronously. In-flight messages are lost.

## Test plan
- Reset then single slot:
  - Stimulus: m2 only valid, mux=3'b001, N=3'b010, message=0xA5…A5.
  - Required: `out_valid`=1 next cycle with identical fields; with `out_ready`=1, `cnt` returns to 0.
- Compaction and drop:
  - Stimulus: m1 mux=3'b111, m2 mux=3'b000, m3 mux=3'b100, all valid, `out_ready`=0.
  - Required: two entries, in order m2 then m3; `drop_count`=1.
- Fill and back-pressure:
  - Stimulus: 3-wide groups each cycle, `out_ready`=0.
  - Required: `cnt` reaches 6 after two groups; `in_ready`=0 next; entries pop in order once `out_ready`=1.
- Overflow flag:
  - Stimulus: present a valid group while `in_ready`=0.
  - Required: no write; `drop_count` unchanged; `overflow_err`=1 until reset.
- Wrap:
  - Stimulus: advance `wp` to 6 via push/pop, then push 3 kept slots.
  - Required: entries land at 6, 7, 0 and drain in order.
- Saturation:
  - Stimulus: force 65536+ drops.
  - Required: `drop_count` holds 16'hFFFF; async `rst` mid-stream clears all state within the same cycle.
